// File: rtl/cpu_div_ctrl.sv
// Sequencer between the execute stage and cpu_divider: takes operand magnitudes,
// pulses start, applies RISC-V divide-by-zero rules and hands results to writeback.
module cpu_div_ctrl #(
  parameter int DEST_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic [DEST_W-1:0] req_dest,
  input  logic              flush,
  output logic              busy,
  output logic              div_start,
  output logic [31:0]       div_numerator,
  output logic [31:0]       div_denominator,
  output logic              div_sign,
  input  logic [31:0]       div_quotient,
  input  logic [31:0]       div_remainder,
  input  logic              div_done,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [31:0]       result_data,
  output logic [DEST_W-1:0] result_dest
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DRAIN, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic        accept, is_signed, is_rem, b_zero, capture;
  logic [31:0] a_mag, b_mag;

  // op[0]=1 marks the unsigned variants, op[1]=1 marks remainder
  assign is_signed = ~req_op[0];
  assign is_rem    = req_op[1];
  assign b_zero    = (req_b == 32'd0);
  assign accept    = (state == S_IDLE) & req_valid & ~flush;
  assign capture   = (state == S_WAIT) & div_done & ~flush;

  // two's-complement negate of 0x80000000 yields 0x80000000, the correct unsigned magnitude
  assign a_mag = (is_signed & req_a[31]) ? (~req_a + 32'd1) : req_a;
  assign b_mag = (is_signed & req_b[31]) ? (~req_b + 32'd1) : req_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = b_zero ? S_HOLD : S_START;
      S_START: state_nxt = flush ? S_DRAIN : S_WAIT;
      // flush coinciding with done has nothing left to drain
      S_WAIT: begin
        if (flush)         state_nxt = div_done ? S_IDLE : S_DRAIN;
        else if (div_done) state_nxt = S_HOLD;
      end
      S_DRAIN: if (div_done) state_nxt = S_IDLE;
      S_HOLD:  if (flush | result_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q            <= 2'd0;
      div_numerator   <= 32'd0;
      div_denominator <= 32'd0;
      div_sign        <= 1'b0;
      result_data     <= 32'd0;
      result_dest     <= '0;
    end else if (accept) begin
      op_q            <= req_op;
      result_dest     <= req_dest;
      div_numerator   <= a_mag;
      div_denominator <= b_mag;
      unique case (req_op)
        2'd0:    div_sign <= req_a[31] ^ req_b[31];
        2'd2:    div_sign <= req_a[31];
        default: div_sign <= 1'b0;
      endcase
      if (b_zero) result_data <= is_rem ? req_a : 32'hFFFF_FFFF;
    end else if (capture) begin
      result_data <= op_q[1] ? div_remainder : div_quotient;
    end
  end

  assign busy         = (state != S_IDLE);
  assign div_start    = (state == S_START);
  assign result_valid = (state == S_HOLD);

endmodule

// File: tb/tb_cpu_div_ctrl.sv
// Randomized bench for cpu_div_ctrl: behavioural divider plus a RISC-V
// DIV/DIVU/REM/REMU arithmetic reference for the returned results.
module tb_cpu_div_ctrl;

  localparam int DEST_W = 5;

  logic              clock, reset_n;
  logic              req_valid, flush, result_ready;
  logic [1:0]        req_op;
  logic [31:0]       req_a, req_b;
  logic [DEST_W-1:0] req_dest;
  logic              busy, div_start, div_sign, div_done, result_valid;
  logic [31:0]       div_numerator, div_denominator, div_quotient, div_remainder, result_data;
  logic [DEST_W-1:0] result_dest;

  cpu_div_ctrl #(.DEST_W(DEST_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_dest(req_dest), .flush(flush), .busy(busy),
    .div_start(div_start), .div_numerator(div_numerator),
    .div_denominator(div_denominator), .div_sign(div_sign),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_dest(result_dest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural divider: unsigned divide of magnitudes, sign applied to both outputs
  logic        running = 1'b0;
  int          lat_cnt = 0, start_cnt = 0, done_cnt = 0, done_cyc = -10;
  logic [31:0] m_n, m_d;
  logic        m_s;
  initial begin div_done = 1'b0; div_quotient = '0; div_remainder = '0; end
  always begin
    @(posedge clock); #2;
    div_done      = 1'b0;
    div_quotient  = $urandom;
    div_remainder = $urandom;
    if (running) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        running       = 1'b0;
        div_done      = 1'b1;
        done_cnt++;
        done_cyc      = cyc;
        div_quotient  = m_s ? -(m_n / m_d) : (m_n / m_d);
        div_remainder = m_s ? -(m_n % m_d) : (m_n % m_d);
      end
    end
    if (div_start) begin
      start_cnt++;
      if (!running) begin
        running = 1'b1;
        m_n = div_numerator; m_d = div_denominator; m_s = div_sign;
        lat_cnt = $urandom_range(2, 7);
      end
    end
  end

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] x);
    return (!op[0] && $signed(x) < 0) ? -x : x;
  endfunction

  function automatic logic ref_sign(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'd0) return ($signed(a) < 0) != ($signed(b) < 0);
    if (op == 2'd2) return $signed(a) < 0;
    return 1'b0;
  endfunction

  // flush_mode: 0 none, 1 flush during WAIT, 2 flush during HOLD
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [DEST_W-1:0] dest, input int hold, input int flush_mode);
    int s0, sd;
    logic got, stable, bad_rv;
    logic [31:0] d0;
    logic [DEST_W-1:0] t0;
    @(negedge clock);
    chk("idle_busy", busy, 1'b0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_dest = dest;
    s0 = start_cnt; sd = done_cnt;
    @(negedge clock);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    if (b == 0) begin
      chk("z_valid", result_valid, 1'b1);
    end else begin
      chk("start", {busy, div_start}, 2'b11);
      chk("numer", div_numerator, mag(op, a));
      chk("denom", div_denominator, mag(op, b));
      chk("sign", div_sign, ref_sign(op, a, b));
      if (flush_mode == 1) begin
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        chk("drain_busy", busy, 1'b1);
        bad_rv = result_valid;
        for (int i = 0; i < 40 && busy; i++) begin
          @(negedge clock);
          bad_rv |= result_valid;
        end
        chk("drain_idle", busy, 1'b0);
        chk("drain_rv", bad_rv, 1'b0);
        chk("drain_done", done_cnt > sd, 1'b1);
        chk("drain_starts", start_cnt - s0, 1);
        return;
      end
      got = 1'b0; stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (result_valid) begin got = 1'b1; break; end
        if (div_numerator !== mag(op, a) || div_denominator !== mag(op, b) || div_start) stable = 1'b0;
      end
      chk("valid_seen", got, 1'b1);
      if (!got) return;
      chk("opnd_stable", stable, 1'b1);
      chk("latency", cyc, done_cyc + 1);
    end
    chk("starts", start_cnt - s0, (b == 0) ? 0 : 1);
    chk("data", result_data, ref_res(op, a, b));
    chk("dest", result_dest, dest);
    if (flush_mode == 2) begin
      flush = 1'b1;
      @(negedge clock); flush = 1'b0;
      chk("hold_flush", {busy, result_valid}, 2'b00);
      return;
    end
    d0 = result_data; t0 = result_dest; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!result_valid || result_data !== d0 || result_dest !== t0) stable = 1'b0;
    end
    chk("hold_stable", stable, 1'b1);
    result_ready = 1'b1;
    @(negedge clock); result_ready = 1'b0;
    chk("ready_idle", {busy, result_valid}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    reset_n = 1'b0; req_valid = 1'b0; flush = 1'b0; result_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_dest = '0;
    #3;
    chk("rst_outs", {busy, div_start, result_valid, div_sign}, 4'b0);
    chk("rst_data", {div_numerator, div_denominator, result_data, 27'd0, result_dest}, '0);
    @(negedge clock); reset_n = 1'b1;

    do_req(2'd1, 32'd100, 32'd7, 5'd3, 1, 0);
    do_req(2'd0, 32'hFFFF_FF9C, 32'd7, 5'd4, 0, 0);
    do_req(2'd2, 32'hFFFF_FF9C, 32'd7, 5'd5, 0, 0);
    do_req(2'd0, 32'd5, 32'd0, 5'd6, 0, 0);
    do_req(2'd2, 32'hFFFF_FFFB, 32'd0, 5'd7, 0, 0);
    do_req(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0);
    do_req(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 0);
    do_req(2'd1, 32'd1000, 32'd10, 5'd10, 0, 1);
    do_req(2'd1, 32'd9, 32'd3, 5'd11, 0, 0);
    do_req(2'd3, 32'd77, 32'd5, 5'd12, 5, 0);
    do_req(2'd1, 32'd50, 32'd5, 5'd13, 0, 2);

    // request alongside flush in IDLE is dropped
    @(negedge clock);
    req_valid = 1'b1; flush = 1'b1; req_op = 2'd1; req_a = 32'd8; req_b = 32'd0;
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush", {busy, result_valid}, 2'b00);

    // async reset in the middle of WAIT
    @(negedge clock);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd1000; req_b = 32'd10; req_dest = 5'd21;
    @(negedge clock); req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0; #1;
    chk("mid_rst_ctl", {busy, div_start, result_valid, div_sign}, 4'b0);
    chk("mid_rst_dat", {div_numerator, div_denominator, result_data, 27'd0, result_dest}, '0);
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 40 && running; i++) @(negedge clock);
    @(negedge clock);
    chk("post_rst_idle", {busy, result_valid}, 2'b00);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = $urandom_range(0, 200);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        3: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      do_req(2'($urandom_range(0, 3)), ra, rb, DEST_W'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? (rb == 0 ? 2 : 1) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_div_ctrl.md
Name: cpu_div_ctrl

Overview:
- Sequencing front-end between the CPU execute stage and cpu_divider.
- Accepts DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes.
- Pulses the divider's start and waits for its done, then applies the correct result sign and the RISC-V divide-by-zero rules.
- Returns the result to writeback over a valid/ready handshake and stalls the pipeline while busy.

Parameters:
- DEST_W, 5, width of destination register tag carried with the request.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a divide request
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_a  in  32  dividend
- req_b  in  32  divisor
- req_dest  in  DEST_W  destination tag
- flush  in  1  pipeline kill; discard in-flight request
- busy  out  1  stall to execute stage; high whenever state != IDLE
- div_start  out  1  one-cycle start pulse to cpu_divider
- div_numerator  out  32  registered magnitude of dividend
- div_denominator  out  32  registered magnitude of divisor
- div_sign  out  1  sign flag to cpu_divider
- div_quotient  in  32  from cpu_divider
- div_remainder  in  32  from cpu_divider
- div_done  in  1  from cpu_divider
- result_valid  out  1  result available
- result_ready  in  1  writeback accepts result
- result_data  out  32  selected, sign-corrected result
- result_dest  out  DEST_W  tag of result

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, div_start, result_valid=0; div_numerator, div_denominator, result_data=0; div_sign=0; result_dest=0.
- States: IDLE, START, WAIT, DRAIN, HOLD.
- IDLE, on req_valid & !flush:
  - Latch op, dest and original req_a.
  - Signed ops (DIV, REM): numerator=|a|, denominator=|b|. |0x80000000| = 0x80000000 (unsigned).
  - div_sign: DIV = a[31]^b[31]; REM = a[31]; unsigned ops = 0.
  - If req_b==0: skip the divider and go to HOLD with result_data = 0xFFFFFFFF for DIV/DIVU, or the original req_a for REM/REMU.
  - Otherwise go to START.
- req_valid & flush in the same IDLE cycle: request ignored.
- START: div_start=1 for exactly this cycle; operand registers stay stable from here until div_done. Next state WAIT.
- WAIT: hold operands. On div_done=1, capture result_data = div_quotient for DIV/DIVU or div_remainder for REM/REMU, then go to HOLD. Sign is already applied by the divider via div_sign.
- Overflow case (-2^31 / -1): the result falls out naturally as quotient 0x80000000, remainder 0. No special case.
- HOLD: result_valid=1, data and dest stable. On result_ready=1, go to IDLE the next cycle. A new request is not accepted in that same cycle; back-to-back requests start from IDLE.
- flush in START or WAIT: go to DRAIN. The divider has no abort, so the divider keeps running. DRAIN waits for div_done, drops the result and returns to IDLE. result_valid is never asserted for a flushed op.
- flush in HOLD: result discarded, go to IDLE. flush in DRAIN or IDLE: no effect.
- busy = (state != IDLE), combinational from state.
- Latency: result_valid rises one cycle after div_done is sampled high. Divide-by-zero: result_valid rises the cycle after acceptance.
- Reset mid-operation: returns to IDLE immediately. The divider completes harmlessly and its done is ignored in IDLE.
- div_done seen in IDLE or HOLD: ignored.

Test Plan:
- DIVU a=100, b=7 -> one div_start pulse, numerator=100, denominator=7, sign=0; result_data=14, result_valid one cycle after div_done.
- DIV a=-100 (0xFFFFFF9C), b=7 -> div_sign=1, result 0xFFFFFFF2 (-14). REM same operands -> result 0xFFFFFFFE (-2).
- DIV a=5, b=0 -> no div_start; result_valid next cycle, data 0xFFFFFFFF. REM a=-5, b=0 -> data 0xFFFFFFFB.
- DIV a=0x80000000, b=0xFFFFFFFF -> result 0x80000000. REM same operands -> result 0.
- DIVU 1000/10 with flush asserted mid-WAIT -> state DRAIN, busy held until div_done, no result_valid; a following DIVU 9/3 returns 3 correctly.
- Result with result_ready held low for 5 cycles -> result_valid, data and dest stable throughout; IDLE the cycle after ready=1. Async reset_n=0 mid-WAIT -> all outputs 0 immediately.
